rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8_pkg.sv | 17 +
 rtl/rr_arbiter_8_prio_enc.sv | 25 ++
 rtl/rr_arbiter_8.sv | 99 +++++++++
 tb/tb_rr_arbiter_8.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding,
// requester count / index width, and a one-hot decode helper.
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_prio_enc.sv
// Rotating priority search: first set req bit at or above ptr, wrapping 7->0.
// Purely combinational.
module rr_prio_enc8
    import rr_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the farthest offset down so the nearest request to ptr
    // is the last assignment and therefore wins. Index math wraps mod 8.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + IDX_W'(i)]) begin
                idx = ptr + IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a bounded hold time per grant.
// All outputs are registered; req reaches gnt one cycle after it is sampled.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 4  // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [3:0]       hold_cnt, hold_n;
    logic [N_REQ-1:0] gnt_n;
    logic [IDX_W-1:0] idx_n;
    logic             vld_n;

    logic [IDX_W-1:0] win_idx;
    logic             win_any;

    rr_prio_enc8 u_prio (
        .req (req),
        .ptr (ptr),
        .idx (win_idx),
        .any (win_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= vld_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        vld_n   = gnt_valid;

        unique case (state)
            IDLE: begin
                if (win_any) begin
                    state_n = GRANT;
                    gnt_n   = idx2onehot(win_idx);
                    idx_n   = win_idx;
                    vld_n   = 1'b1;
                    hold_n  = '0;
                    ptr_n   = win_idx + IDX_W'(1);
                end
            end
            GRANT: begin
                if (req[gnt_idx] && hold_cnt < HOLD_LAST) begin
                    hold_n = hold_cnt + 4'd1;
                end else if (win_any) begin
                    // ptr already sits just past the holder, so an expired holder
                    // only wins again when it is the sole requester.
                    gnt_n  = idx2onehot(win_idx);
                    idx_n  = win_idx;
                    vld_n  = 1'b1;
                    hold_n = '0;
                    ptr_n  = win_idx + IDX_W'(1);
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    vld_n   = 1'b0;
                    hold_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                vld_n   = 1'b0;
                hold_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed scenarios for rr_arbiter_8; expected grants are queued as stimulus
// is applied and popped/compared one cycle later.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int total = 0;
    int bad   = 0;

    // expected entry: {valid, idx}
    logic [3:0] sb_q[$];

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        logic [7:0] eg;
        rst = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(4'h0);
            @(posedge clk); #1;
            e  = sb_q.pop_front();
            eg = 8'h00;
            total++;
            if (gnt !== eg || gnt_idx !== e[2:0] || gnt_valid !== e[3]) begin
                bad++;
                $display("FAIL reset[%0d]: gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                         i, gnt, gnt_idx, gnt_valid, eg, e[2:0], e[3]);
            end
        end
        rst = 1'b0;
        req = 8'h00;
    endtask

    task automatic test_single();
        logic [7:0] rq[2] = '{8'h10, 8'h10};
        logic [3:0] ex[2] = '{4'hC, 4'hC};
        logic [3:0] e;
        logic [7:0] eg;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            req = rq[i];
            sb_q.push_back(ex[i]);
            @(posedge clk); #1;
            e  = sb_q.pop_front();
            eg = e[3] ? (8'h01 << e[2:0]) : 8'h00;
            total++;
            if (gnt !== eg || gnt_idx !== e[2:0] || gnt_valid !== e[3]) begin
                bad++;
                $display("FAIL single[%0d]: gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                         i, gnt, gnt_idx, gnt_valid, eg, e[2:0], e[3]);
            end
        end
    endtask

    // holders drop after one granted cycle; last step shows ptr wrapped to 0
    task automatic test_drop_order();
        logic [7:0] rq[6] = '{8'h91, 8'h90, 8'h80, 8'h00, 8'h81, 8'h00};
        logic [3:0] ex[6] = '{4'h8, 4'hC, 4'hF, 4'h7, 4'h8, 4'h0};
        logic [3:0] e;
        logic [7:0] eg;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req = rq[i];
            sb_q.push_back(ex[i]);
            @(posedge clk); #1;
            e  = sb_q.pop_front();
            eg = e[3] ? (8'h01 << e[2:0]) : 8'h00;
            total++;
            if (gnt !== eg || gnt_idx !== e[2:0] || gnt_valid !== e[3]) begin
                bad++;
                $display("FAIL drop_order[%0d]: gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                         i, gnt, gnt_idx, gnt_valid, eg, e[2:0], e[3]);
            end
        end
    endtask

    task automatic test_max_hold();
        logic [3:0] e;
        logic [7:0] eg;
        do_reset();
        req = 8'h41;
        for (int i = 0; i < 10; i++) begin
            sb_q.push_back((i < 4 || i >= 8) ? 4'h8 : 4'hE);
            @(posedge clk); #1;
            e  = sb_q.pop_front();
            eg = e[3] ? (8'h01 << e[2:0]) : 8'h00;
            total++;
            if (gnt !== eg || gnt_idx !== e[2:0] || gnt_valid !== e[3]) begin
                bad++;
                $display("FAIL max_hold[%0d]: gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                         i, gnt, gnt_idx, gnt_valid, eg, e[2:0], e[3]);
            end
        end
    endtask

    task automatic test_sole_holder();
        logic [3:0] e;
        logic [7:0] eg;
        do_reset();
        req = 8'h04;
        for (int i = 0; i < 10; i++) begin
            sb_q.push_back(4'hA);
            @(posedge clk); #1;
            e  = sb_q.pop_front();
            eg = 8'h04;
            total++;
            if (gnt !== eg || gnt_idx !== e[2:0] || gnt_valid !== e[3]) begin
                bad++;
                $display("FAIL sole_holder[%0d]: gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                         i, gnt, gnt_idx, gnt_valid, eg, e[2:0], e[3]);
            end
        end
    endtask

    task automatic test_release();
        logic [7:0] rq[3] = '{8'h08, 8'h00, 8'h00};
        logic [3:0] ex[3] = '{4'hB, 4'h3, 4'h3};
        logic [3:0] e;
        logic [7:0] eg;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req = rq[i];
            sb_q.push_back(ex[i]);
            @(posedge clk); #1;
            e  = sb_q.pop_front();
            eg = e[3] ? (8'h01 << e[2:0]) : 8'h00;
            total++;
            if (gnt !== eg || gnt_idx !== e[2:0] || gnt_valid !== e[3]) begin
                bad++;
                $display("FAIL release[%0d]: gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                         i, gnt, gnt_idx, gnt_valid, eg, e[2:0], e[3]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rq[4] = '{8'h20, 8'h20, 8'h20, 8'h80};
        logic       rs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] ex[4] = '{4'hD, 4'hD, 4'h0, 4'hF};
        logic [3:0] e;
        logic [7:0] eg;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = rq[i];
            rst = rs[i];
            sb_q.push_back(ex[i]);
            @(posedge clk); #1;
            e  = sb_q.pop_front();
            eg = e[3] ? (8'h01 << e[2:0]) : 8'h00;
            total++;
            if (gnt !== eg || gnt_idx !== e[2:0] || gnt_valid !== e[3]) begin
                bad++;
                $display("FAIL reset_mid[%0d]: gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                         i, gnt, gnt_idx, gnt_valid, eg, e[2:0], e[3]);
            end
        end
        rst = 1'b0;
    endtask

    // a request pulse that falls before the edge must not be seen
    task automatic test_glitch();
        logic [3:0] e;
        logic [7:0] eg;
        do_reset();
        req = 8'h02;
        sb_q.push_back(4'h0);
        #2;
        req = 8'h00;
        @(posedge clk); #1;
        e  = sb_q.pop_front();
        eg = 8'h00;
        total++;
        if (gnt !== eg || gnt_idx !== e[2:0] || gnt_valid !== e[3]) begin
            bad++;
            $display("FAIL glitch: gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                     gnt, gnt_idx, gnt_valid, eg, e[2:0], e[3]);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_drop_order();
        test_max_hold();
        test_sole_holder();
        test_release();
        test_reset_mid();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
